// File: rtl/pool_pkg.sv
// Shared constants, mode encoding and width helper for the streaming pooling unit.
package pool_pkg;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_WINDOW    = 4;
   localparam int DEF_CHANNELS  = 1;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_MIN = 1'b1
   } pool_mode_t;

   // Index width that never collapses to zero bits for a single channel/element.
   function automatic int chan_w(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/pool_sel.sv
// Combinational signed max/min select; a tie keeps the accumulator.
// Zero latency, no flow control.
module pool_sel
   import pool_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 mode_min,
   input  logic [DATA_BITS-1:0] acc,
   input  logic [DATA_BITS-1:0] sample,
   output logic [DATA_BITS-1:0] result
);

   logic take;

   always_comb begin
      take = 1'b0;
      if (pool_mode_t'(mode_min) == POOL_MIN)
         take = $signed(sample) < $signed(acc);
      else
         take = $signed(sample) > $signed(acc);
      result = take ? sample : acc;
   end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming signed max/min pooling over channel-interleaved windows; result registered one cycle after the final element.
// Full backpressure: in_ready drops while a result is held with out_ready low, and during clear.
module maxpool_stream
   import pool_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int WINDOW    = DEF_WINDOW,
   parameter int CHANNELS  = DEF_CHANNELS,
   localparam int CW       = chan_w(CHANNELS),
   localparam int EW       = chan_w(WINDOW)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 mode_min,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic [CW-1:0]        out_chan
);

   logic [CW-1:0]        chan_cnt;
   logic [EW-1:0]        elem_cnt;
   pool_mode_t           mode_q;
   logic [DATA_BITS-1:0] acc [CHANNELS];
   logic [DATA_BITS-1:0] acc_cur;
   logic [DATA_BITS-1:0] acc_next;
   logic [DATA_BITS-1:0] fin_sel;
   logic [DATA_BITS-1:0] fin_data;
   logic                 accept;
   logic                 chan_last;
   logic                 elem_first;
   logic                 elem_last;

   assign in_ready   = !clear && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign chan_last  = (chan_cnt == CW'(CHANNELS - 1));
   assign elem_first = (elem_cnt == '0);
   assign elem_last  = (elem_cnt == EW'(WINDOW - 1));

   always_comb begin
      acc_cur = acc[0];
      for (int i = 1; i < CHANNELS; i++)
         if (chan_cnt == CW'(i))
            acc_cur = acc[i];
   end

   pool_sel #(.DATA_BITS(DATA_BITS)) u_sel_acc (
      .mode_min (mode_q == POOL_MIN),
      .acc      (acc_cur),
      .sample   (in_data),
      .result   (acc_next)
   );

   pool_sel #(.DATA_BITS(DATA_BITS)) u_sel_out (
      .mode_min (mode_q == POOL_MIN),
      .acc      (acc_cur),
      .sample   (in_data),
      .result   (fin_sel)
   );

   // A one-element window has nothing to compare against, so the sample passes through.
   assign fin_data = elem_first ? in_data : fin_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chan_cnt  <= '0;
         elem_cnt  <= '0;
         mode_q    <= POOL_MAX;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         for (int i = 0; i < CHANNELS; i++)
            acc[i] <= '0;
      end else if (clear) begin
         chan_cnt  <= '0;
         elem_cnt  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            if (elem_first && chan_cnt == '0)
               mode_q <= pool_mode_t'(mode_min);
            if (elem_last) begin
               out_data  <= fin_data;
               out_chan  <= chan_cnt;
               out_valid <= 1'b1;
            end else begin
               for (int i = 0; i < CHANNELS; i++)
                  if (chan_cnt == CW'(i))
                     acc[i] <= elem_first ? in_data : acc_next;
            end
            if (chan_last) begin
               chan_cnt <= '0;
               elem_cnt <= elem_last ? '0 : elem_cnt + 1'b1;
            end else begin
               chan_cnt <= chan_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench: directed vectors and corner sequences on two instances, random streams on six configurations.
module tb_maxpool_stream;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rnd_done = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mark_done();
      rnd_done++;
   endtask

   // ---------------- instance A: WINDOW=4, CHANNELS=1 ----------------
   logic       a_reset, a_clear, a_mode, a_iv, a_ir, a_ov, a_or;
   logic [7:0] a_id, a_od;
   logic [0:0] a_oc;

   maxpool_stream #(.DATA_BITS(8), .WINDOW(4), .CHANNELS(1)) u_a (
      .clk(clk), .reset(a_reset), .clear(a_clear), .mode_min(a_mode),
      .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_chan(a_oc)
   );

   // ---------------- instance B: WINDOW=4, CHANNELS=2 ----------------
   logic       b_reset, b_clear, b_mode, b_iv, b_ir, b_ov, b_or;
   logic [7:0] b_id, b_od;
   logic [0:0] b_oc;

   maxpool_stream #(.DATA_BITS(8), .WINDOW(4), .CHANNELS(2)) u_b (
      .clk(clk), .reset(b_reset), .clear(b_clear), .mode_min(b_mode),
      .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_chan(b_oc)
   );

   // Drive one sample, confirm the expected ready, then advance to just after the edge.
   task automatic a_push(input logic [7:0] d, input logic exp_rdy, input string name);
      a_iv = 1'b1;
      a_id = d;
      #1;
      chk(name, int'(a_ir), int'(exp_rdy));
      @(posedge clk);
      #1;
      a_iv = 1'b0;
   endtask

   task automatic b_push(input logic [7:0] d);
      b_iv = 1'b1;
      b_id = d;
      #1;
      chk("b_in_ready", int'(b_ir), 1);
      @(posedge clk);
      #1;
      b_iv = 1'b0;
   endtask

   task automatic a_result(input string name, input int exp);
      chk({name, "_valid"}, int'(a_ov), 1);
      chk({name, "_data"}, $signed(a_od), exp);
      chk({name, "_chan"}, int'(a_oc), 0);
   endtask

   typedef struct {
      logic             mode;
      logic [3:0][7:0]  d;
      int               exp;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{1'b0, {8'd2,   8'd7,   -8'sd5,   8'd3},   7};
      vt[1] = '{1'b0, {8'd0,  -8'sd1,  -8'sd128, 8'd127}, 127};
      vt[2] = '{1'b0, {8'd4,   8'd4,   8'd4,     8'd4},   4};
      vt[3] = '{1'b1, {8'd2,   8'd7,   -8'sd5,   8'd3},   -5};
      vt[4] = '{1'b1, {8'd0,  -8'sd1,  -8'sd128, 8'd127}, -128};
      vt[5] = '{1'b1, {8'd5,  -8'sd2,  -8'sd1,  -8'sd1},  -2};

      a_reset = 1'b1; a_clear = 1'b0; a_mode = 1'b0; a_iv = 1'b0; a_id = '0; a_or = 1'b1;
      b_reset = 1'b1; b_clear = 1'b0; b_mode = 1'b0; b_iv = 1'b0; b_id = '0; b_or = 1'b1;
      #3;
      chk("rst_in_ready", int'(a_ir), 1);
      chk("rst_out_valid", int'(a_ov), 0);
      chk("rst_out_data", int'(a_od), 0);
      chk("rst_out_chan", int'(a_oc), 0);
      chk("rst_b_out_valid", int'(b_ov), 0);
      #9;
      a_reset = 1'b0;
      b_reset = 1'b0;
      @(posedge clk);
      #1;

      // Table vectors, back to back; mode flips after element 0 must not matter.
      for (int i = 0; i < 6; i++) begin
         for (int e = 0; e < 4; e++) begin
            a_mode = (e == 0) ? vt[i].mode : ~vt[i].mode;
            a_push(vt[i].d[e], 1'b1, "vec_in_ready");
            a_iv = (i < 5 || e < 3);
         end
         a_result("vec", vt[i].exp);
      end
      a_iv = 1'b0;
      @(posedge clk);
      #1;
      chk("drain_valid", int'(a_ov), 0);

      // Output stall for 5 cycles, then the next window streams without a bubble.
      a_or = 1'b0;
      a_mode = 1'b0;
      a_push(8'd1, 1'b1, "bp_fill_ready");
      a_push(8'd2, 1'b1, "bp_fill_ready");
      a_push(8'd3, 1'b1, "bp_fill_ready");
      a_push(8'd4, 1'b1, "bp_fill_ready");
      a_result("bp_first", 4);
      for (int k = 0; k < 5; k++) begin
         a_push(8'd99, 1'b0, "bp_stall_ready");
         a_result("bp_hold", 4);
      end
      a_or = 1'b1;
      a_push(8'd10, 1'b1, "bp_release_ready");
      chk("bp_dropped", int'(a_ov), 0);
      a_push(8'd20, 1'b1, "bp_stream_ready");
      a_push(8'd5,  1'b1, "bp_stream_ready");
      a_push(8'd6,  1'b1, "bp_stream_ready");
      a_result("bp_next", 20);
      @(posedge clk);
      #1;

      // Clear aborts a partial window and swallows the sample offered alongside it.
      a_push(8'd50, 1'b1, "clr_ready");
      a_push(8'd60, 1'b1, "clr_ready");
      a_clear = 1'b1;
      a_push(8'd100, 1'b0, "clr_in_ready");
      a_clear = 1'b0;
      a_push(8'd1, 1'b1, "clr_ready");
      a_push(8'd9, 1'b1, "clr_ready");
      chk("clr_no_early", int'(a_ov), 0);
      a_push(8'd2, 1'b1, "clr_ready");
      a_push(8'd3, 1'b1, "clr_ready");
      a_result("clr", 9);
      a_or = 1'b0;
      a_clear = 1'b1;
      @(posedge clk);
      #1;
      a_clear = 1'b0;
      a_or = 1'b1;
      chk("clr_discard", int'(a_ov), 0);

      // Asynchronous reset mid-window.
      a_push(8'd100, 1'b1, "rstw_ready");
      a_push(8'd110, 1'b1, "rstw_ready");
      #2;
      a_reset = 1'b1;
      #1;
      chk("rstw_in_ready", int'(a_ir), 1);
      chk("rstw_out_valid", int'(a_ov), 0);
      #2;
      a_reset = 1'b0;
      @(posedge clk);
      #1;
      a_push(8'd1, 1'b1, "rstw_ready");
      a_push(8'd2, 1'b1, "rstw_ready");
      a_push(8'd3, 1'b1, "rstw_ready");
      a_push(8'd4, 1'b1, "rstw_ready");
      a_result("rstw", 4);

      // Asynchronous reset while a result is stalled.
      a_or = 1'b0;
      @(posedge clk);
      #2;
      a_reset = 1'b1;
      #1;
      chk("rsts_out_valid", int'(a_ov), 0);
      chk("rsts_out_data", int'(a_od), 0);
      chk("rsts_out_chan", int'(a_oc), 0);
      chk("rsts_in_ready", int'(a_ir), 1);
      #2;
      a_reset = 1'b0;
      a_or = 1'b1;
      @(posedge clk);
      #1;
      a_push(8'd5,   1'b1, "rsts_ready");
      a_push(-8'sd3, 1'b1, "rsts_ready");
      a_push(8'd8,   1'b1, "rsts_ready");
      a_push(-8'sd9, 1'b1, "rsts_ready");
      a_result("rsts", 8);

      // Two channels, min pooling.
      b_mode = 1'b1;
      b_push(-8'sd128); b_push(8'd127);
      b_push(8'd5);     b_push(-8'sd1);
      b_push(8'd0);     b_push(8'd0);
      b_push(-8'sd7);
      chk("b_ch0_valid", int'(b_ov), 1);
      chk("b_ch0_data", $signed(b_od), -128);
      chk("b_ch0_chan", int'(b_oc), 0);
      b_push(8'd100);
      chk("b_ch1_valid", int'(b_ov), 1);
      chk("b_ch1_data", $signed(b_od), -1);
      chk("b_ch1_chan", int'(b_oc), 1);

      for (int k = 0; k < 20000 && rnd_done < 6; k++)
         @(posedge clk);
      chk("rnd_finished", rnd_done, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- random streams against a window-level model ----------------
   for (genvar g = 0; g < 6; g++) begin : rnd
      localparam int W   = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 4 : 9;
      localparam int C   = (g < 3) ? 1 : 3;
      localparam int CWL = (C > 1) ? $clog2(C) : 1;

      logic           rst, clr, md, iv, ir, ov, ordy;
      logic [7:0]     id, od;
      logic [CWL-1:0] oc;
      int             win [0:C*W-1];
      int             expd [$];
      int             expc [$];

      maxpool_stream #(.DATA_BITS(8), .WINDOW(W), .CHANNELS(C)) dut (
         .clk(clk), .reset(rst), .clear(clr), .mode_min(md),
         .in_valid(iv), .in_ready(ir), .in_data(id),
         .out_valid(ov), .out_ready(ordy), .out_data(od), .out_chan(oc)
      );

      initial begin
         int  pos;
         int  ch;
         int  r;
         int  v;
         logic wmode;
         logic [7:0] edges [4];
         edges[0] = 8'h80; edges[1] = 8'h7f; edges[2] = 8'h00; edges[3] = 8'hff;
         pos = 0;
         wmode = 1'b0;
         rst = 1'b1; clr = 1'b0; md = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
         #12;
         rst = 1'b0;
         for (int cyc = 0; cyc < 1510; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 1500) begin
               iv   = ($urandom_range(0, 3) != 0);
               id   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
               md   = 1'($urandom);
               ordy = ($urandom_range(0, 3) != 0);
               clr  = ($urandom_range(0, 60) == 0);
            end else begin
               iv = 1'b0; clr = 1'b0; ordy = 1'b1;
            end
            @(negedge clk);
            chk("rnd_in_ready", int'(ir), int'(!clr && (expd.size() == 0 || ordy)));
            chk("rnd_out_valid", int'(ov), int'(expd.size() > 0));
            if (ov && expd.size() > 0) begin
               chk("rnd_data", $signed(od), expd[0]);
               chk("rnd_chan", int'(oc), expc[0]);
               if (ordy) begin
                  void'(expd.pop_front());
                  void'(expc.pop_front());
               end
            end
            if (clr) begin
               pos = 0;
               expd.delete();
               expc.delete();
            end else if (iv && ir) begin
               if (pos == 0)
                  wmode = md;
               win[pos] = $signed(id);
               if (pos >= C * (W - 1)) begin
                  ch = pos - C * (W - 1);
                  r  = win[ch];
                  for (int e = 1; e < W; e++) begin
                     v = win[ch + C * e];
                     r = wmode ? ((v < r) ? v : r) : ((v > r) ? v : r);
                  end
                  expd.push_back(r);
                  expc.push_back(ch);
               end
               pos = (pos + 1) % (C * W);
            end
         end
         chk("rnd_leftover", expd.size(), 0);
         mark_done();
      end
   end

endmodule
